// File: rtl/smoothgrad_polar_stream_sequencer_8ch.sv
// ---------------------------------------------------------------------------
// smoothgrad_polar_stream_sequencer_8ch
//
// Upstream feeder for the 8-channel polar smooth-gradient accumulator.
// On an accepted START it latches eight gradient magnitudes and signs, then
// walks the channels round-robin (0..7 = one sweep) for FRAME_LEN sweeps.
// Each cycle the active channel's magnitude is compared against a free
// running Fibonacci LFSR to produce one unipolar stochastic bit, so over a
// full LFSR period the bit density of channel k is mag_k / (2^N - 1).
//
// Ports
//   CLK        rising-edge clock
//   INIT_n     asynchronous active-low reset
//   START      frame request, only honoured in IDLE
//   STOP       abort the running frame (wins over HOLD)
//   HOLD       pause: freezes LFSR, counters and registered outputs
//   GRAD_MAG   packed magnitudes, channel k at [k*N +: N]
//   GRAD_SIGN  per-channel signs
//   IN_SS      stochastic bits, one per channel (only the active bit updates)
//   SIGN       signs latched at START acceptance
//   regIndex   active channel
//   EN         accumulator update enable (combinational: RUN & ~HOLD)
//   BUSY       high while in RUN, including held cycles
//   DONE       one-cycle pulse after the last cycle of the frame
//
// Handshake: EN is a valid-only qualifier towards the accumulator. There is
// no ready; the accumulator must consume {IN_SS[regIndex], SIGN[regIndex],
// regIndex} on every rising CLK edge where EN=1 and ignore all others.
// BUSY and DONE expose the FSM state (RUN and DONE respectively; both low
// means IDLE).
// ---------------------------------------------------------------------------
module smoothgrad_polar_stream_sequencer_8ch #(
    parameter int             N         = 8,
    parameter int             FRAME_LEN = 256,
    parameter logic [N-1:0]   LFSR_SEED = N'('hA5)
) (
    input  logic             CLK,
    input  logic             INIT_n,
    input  logic             START,
    input  logic             STOP,
    input  logic             HOLD,
    input  logic [8*N-1:0]   GRAD_MAG,
    input  logic [7:0]       GRAD_SIGN,
    output logic [7:0]       IN_SS,
    output logic [7:0]       SIGN,
    output logic [2:0]       regIndex,
    output logic             EN,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Feedback taps at bits N-1, N-3, N-4, N-5 (7,5,4,3 for N=8), which is
    // the maximal-length polynomial x^8+x^6+x^5+x^4+1.
    localparam logic [N-1:0] TAP_MASK =
        N'((1 << (N-1)) | (1 << (N-3)) | (1 << (N-4)) | (1 << (N-5)));

    localparam logic [15:0] LAST_SWEEP = 16'(FRAME_LEN - 1);

    state_t         state;
    logic [N-1:0]   lfsr;
    logic [15:0]    sweep_cnt;
    logic [8*N-1:0] mag_sh;

    logic [N-1:0]   lfsr_next;
    logic [2:0]     idx_next;
    logic [N-1:0]   mag_arr [8];
    logic [N-1:0]   mag_next;
    logic           last_step;
    logic           seed_bit;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            mag_arr[k] = mag_sh[k*N +: N];
        end
    end

    assign lfsr_next = {lfsr[N-2:0], ^(lfsr & TAP_MASK)};
    assign idx_next  = regIndex + 3'd1;
    assign mag_next  = mag_arr[idx_next];

    // The final cycle of a frame is regIndex=7 of sweep FRAME_LEN-1.
    assign last_step = (regIndex == 3'd7) && (sweep_cnt == LAST_SWEEP);

    // First bit of a frame uses the seed itself against the incoming mag0,
    // since the shadow register is only being loaded on that same edge.
    assign seed_bit = (LFSR_SEED <= GRAD_MAG[N-1:0]);

    // Only EN is combinational so that a HOLD raised in this cycle already
    // suppresses the accumulator update at the coming edge.
    assign EN = (state == ST_RUN) && !HOLD;

    always_ff @(posedge CLK or negedge INIT_n) begin
        if (!INIT_n) begin
            state     <= ST_IDLE;
            lfsr      <= LFSR_SEED;
            sweep_cnt <= '0;
            mag_sh    <= '0;
            IN_SS     <= '0;
            SIGN      <= '0;
            regIndex  <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        state     <= ST_RUN;
                        BUSY      <= 1'b1;
                        mag_sh    <= GRAD_MAG;
                        SIGN      <= GRAD_SIGN;
                        lfsr      <= LFSR_SEED;
                        regIndex  <= 3'd0;
                        sweep_cnt <= '0;
                        // Other bits are already zero after reset/STOP/DONE.
                        IN_SS     <= {7'b0, seed_bit};
                    end
                end

                ST_RUN: begin
                    if (STOP) begin
                        // Abort: SIGN and regIndex deliberately hold.
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                        IN_SS <= '0;
                    end else if (!HOLD) begin
                        lfsr     <= lfsr_next;
                        regIndex <= idx_next;
                        if (regIndex == 3'd7) begin
                            sweep_cnt <= sweep_cnt + 16'd1;
                        end
                        if (last_step) begin
                            state <= ST_DONE;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            IN_SS <= '0;
                        end else begin
                            IN_SS[idx_next] <= (lfsr_next <= mag_next);
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    DONE  <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                    IN_SS <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smoothgrad_polar_stream_sequencer_8ch.sv
// ---------------------------------------------------------------------------
// Bench for smoothgrad_polar_stream_sequencer_8ch.
// Two instances share all inputs except START: dut_a runs short frames
// (FRAME_LEN=4), dut_b runs the full-period density frame (FRAME_LEN=255).
// The reference is an array holding the LFSR sequence plus a per-frame queue
// of expected IN_SS vectors, one entry per non-held RUN step.
// ---------------------------------------------------------------------------
module tb_smoothgrad_polar_stream_sequencer_8ch;

    localparam int         FL_A = 4;
    localparam int         FL_B = 255;
    localparam logic [7:0] SEED = 8'hA5;

    // ---------------- clock / reset ----------------
    logic        CLK = 1'b0;
    logic        INIT_n = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        STOP = 1'b0;
    logic        HOLD = 1'b0;
    logic [63:0] GRAD_MAG = '0;
    logic [7:0]  GRAD_SIGN = '0;

    always #5 CLK = ~CLK;

    logic [7:0] ss_a, sign_a, ss_b, sign_b;
    logic [2:0] idx_a, idx_b;
    logic       en_a, busy_a, done_a, en_b, busy_b, done_b;

    smoothgrad_polar_stream_sequencer_8ch #(.N(8), .FRAME_LEN(FL_A), .LFSR_SEED(SEED)) dut_a (
        .CLK(CLK), .INIT_n(INIT_n), .START(start_a), .STOP(STOP), .HOLD(HOLD),
        .GRAD_MAG(GRAD_MAG), .GRAD_SIGN(GRAD_SIGN),
        .IN_SS(ss_a), .SIGN(sign_a), .regIndex(idx_a), .EN(en_a), .BUSY(busy_a), .DONE(done_a)
    );

    smoothgrad_polar_stream_sequencer_8ch #(.N(8), .FRAME_LEN(FL_B), .LFSR_SEED(SEED)) dut_b (
        .CLK(CLK), .INIT_n(INIT_n), .START(start_b), .STOP(STOP), .HOLD(HOLD),
        .GRAD_MAG(GRAD_MAG), .GRAD_SIGN(GRAD_SIGN),
        .IN_SS(ss_b), .SIGN(sign_b), .regIndex(idx_b), .EN(en_b), .BUSY(busy_b), .DONE(done_b)
    );

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         failures = 0;
    logic [7:0] seq [255];
    logic [7:0] exp_q [$];
    int         obs_cnt [8];

    logic [7:0] o_ss, o_sign;
    logic [2:0] o_idx;
    logic       o_en, o_busy, o_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sample(input bit use_b);
        o_ss   = use_b ? ss_b   : ss_a;
        o_sign = use_b ? sign_b : sign_a;
        o_idx  = use_b ? idx_b  : idx_a;
        o_en   = use_b ? en_b   : en_a;
        o_busy = use_b ? busy_b : busy_a;
        o_done = use_b ? done_b : done_a;
    endtask

    task automatic check_quiet(input string tag, input bit use_b);
        sample(use_b);
        check({tag, "_ss"},   32'(o_ss),   32'd0);
        check({tag, "_en"},   32'(o_en),   32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
    endtask

    // Maximal-length LFSR sequence from the seed: shift left, new LSB is the
    // parity of bits 7,5,4,3.
    task automatic build_seq();
        logic [7:0] v;
        v = SEED;
        for (int i = 0; i < 255; i++) begin
            seq[i] = v;
            v = {v[6:0], 1'b0} | 8'($countones(v & 8'hB8) % 2);
        end
    endtask

    // ---------------- driver ----------------
    // Runs one frame request on the selected instance and checks every cycle.
    // hold_step/stop_step/rst_step are RUN step indices (-1 = unused).
    task automatic run_frame(input bit use_b, input int fl, input logic [63:0] mags,
                             input logic [7:0] signs, input int hold_step, input int hold_len,
                             input int stop_step, input int rst_step, input bit noise);
        logic [7:0] vec;
        int  t, held, run_cycles;
        bit  fin, was_stop, was_rst;

        exp_q.delete();
        vec = '0;
        for (int s = 0; s < 8 * fl; s++) begin
            vec[3'(s % 8)] = (seq[s % 255] <= mags[(s % 8) * 8 +: 8]);
            exp_q.push_back(vec);
        end
        for (int k = 0; k < 8; k++) obs_cnt[k] = 0;

        @(posedge CLK); #1;
        GRAD_MAG = mags; GRAD_SIGN = signs;
        start_a = !use_b; start_b = use_b; STOP = 0; HOLD = 0;
        #1;
        sample(use_b);
        check("req_busy", 32'(o_busy), 32'd0);
        check("req_en",   32'(o_en),   32'd0);

        t = 0; held = 0; run_cycles = 0; fin = 0; was_stop = 0; was_rst = 0;
        while (!fin) begin
            @(posedge CLK); #1;
            start_a = 0; start_b = 0;
            if (noise && $urandom_range(0, 2) == 0) begin
                GRAD_MAG = {$urandom, $urandom};
                start_a = !use_b; start_b = use_b;
            end
            HOLD = (t == hold_step) && (held < hold_len);
            STOP = (t == stop_step);
            if (STOP && $urandom_range(0, 1) == 1) HOLD = 1;
            #1;
            sample(use_b);
            run_cycles++;
            check("run_idx",  32'(o_idx),  32'(t % 8));
            check("run_ss",   32'(o_ss),   32'(exp_q[0]));
            check("run_sign", 32'(o_sign), 32'(signs));
            check("run_busy", 32'(o_busy), 32'd1);
            check("run_en",   32'(o_en),   32'(!HOLD));
            check("run_done", 32'(o_done), 32'd0);
            if (!HOLD && o_ss[o_idx]) obs_cnt[o_idx]++;

            if (t == rst_step) begin
                start_a = 0; start_b = 0; STOP = 0; HOLD = 0;
                INIT_n = 0;
                #1;
                check_quiet("rst_now", use_b);
                check("rst_idx",  32'(o_idx),  32'd0);
                check("rst_sign", 32'(o_sign), 32'd0);
                @(negedge CLK);
                INIT_n = 1;
                was_rst = 1; fin = 1;
            end else if (STOP) begin
                was_stop = 1; fin = 1;
            end else if (!HOLD) begin
                void'(exp_q.pop_front());
                t++;
                if (t == 8 * fl) fin = 1;
            end else begin
                held++;
            end
        end

        @(posedge CLK); #1;
        start_a = 0; start_b = 0; STOP = 0; HOLD = 0;
        #1;
        sample(use_b);
        if (was_rst) begin
            check_quiet("post_rst", use_b);
            check("post_rst_idx", 32'(o_idx), 32'd0);
        end else if (was_stop) begin
            check_quiet("stop", use_b);
            check("stop_idx",  32'(o_idx),  32'(t % 8));
            check("stop_sign", 32'(o_sign), 32'(signs));
        end else begin
            check("done_pulse", 32'(o_done), 32'd1);
            check("done_busy",  32'(o_busy), 32'd0);
            check("done_en",    32'(o_en),   32'd0);
            check("done_ss",    32'(o_ss),   32'd0);
            check("run_len",    32'(run_cycles), 32'(8 * fl + hold_len));
        end
        // One more cycle: back in IDLE with no (further) DONE.
        @(posedge CLK); #2;
        check_quiet("after", use_b);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int exp5;
        logic [63:0] m;

        build_seq();

        // Reset and idle.
        #2;
        check_quiet("in_rst_a", 0);
        check_quiet("in_rst_b", 1);
        @(negedge CLK);
        INIT_n = 1;
        for (int c = 0; c < 20; c++) begin
            @(posedge CLK); #2;
            check_quiet("idle_a", 0);
            check_quiet("idle_b", 1);
            check("idle_idx", 32'(idx_a), 32'd0);
        end

        // All-ones frame: every stream bit is 1, DONE after 32 RUN cycles.
        run_frame(0, FL_A, {8{8'hFF}}, 8'h5A, -1, 0, -1, -1, 0);

        // Density frame over one full LFSR period.
        m = {$urandom, $urandom};
        m[3*8 +: 8] = 8'h00;
        m[5*8 +: 8] = 8'h80;
        m[7*8 +: 8] = 8'hFF;
        run_frame(1, FL_B, m, 8'($urandom), -1, 0, -1, -1, 0);
        exp5 = 0;
        for (int s = 5; s < 8 * FL_B; s += 8) if (seq[s % 255] <= 8'h80) exp5++;
        check("dens_ch3", 32'(obs_cnt[3]), 32'd0);
        check("dens_ch5", 32'(obs_cnt[5]), 32'(exp5));
        check("dens_ch5_band", 32'(obs_cnt[5] >= 120 && obs_cnt[5] <= 136), 32'd1);
        check("dens_ch7", 32'(obs_cnt[7]), 32'd255);

        // HOLD for 5 cycles at regIndex=3.
        run_frame(0, FL_A, {$urandom, $urandom}, 8'($urandom), 8 + 3, 5, -1, -1, 0);

        // STOP at sweep 2, regIndex 4, then a fresh frame restarts from the seed.
        run_frame(0, FL_A, {$urandom, $urandom}, 8'($urandom), -1, 0, 2 * 8 + 4, -1, 0);
        run_frame(0, FL_A, {$urandom, $urandom}, 8'($urandom), -1, 0, -1, -1, 0);

        // START pulses with new magnitudes while running are ignored.
        run_frame(0, FL_A, {$urandom, $urandom}, 8'($urandom), -1, 0, -1, -1, 1);

        // Reset during sweep 1.
        run_frame(0, FL_A, {$urandom, $urandom}, 8'($urandom), -1, 0, -1, 8 + 2, 1);

        // A few random frames, with a random HOLD position.
        for (int r = 0; r < 3; r++) begin
            run_frame(0, FL_A, {$urandom, $urandom}, 8'($urandom),
                      $urandom_range(0, 8 * FL_A - 1), $urandom_range(0, 4), -1, -1, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/smoothgrad_polar_stream_sequencer_8ch.md
# smoothgrad_polar_stream_sequencer_8ch

Upstream feeder for the 8-channel polar smooth-gradient accumulator. Latches eight signed gradient magnitudes and converts each to a unipolar stochastic bit stream (LFSR comparison). Time-multiplexes channels round-robin, driving the accumulator's `IN_SS`, `SIGN`, `regIndex` and `EN` inputs. Runs one training frame of `FRAME_LEN` sweeps per `START`, then reports `DONE`.

## Interface
- `N`, 8: gradient magnitude width and LFSR width.
- `FRAME_LEN`, 256: sweeps per frame; one sweep is 8 cycles (channels 0..7). Range 1..65535.
- `LFSR_SEED`, 8'hA5: LFSR value after reset and on each `START` acceptance. Must be nonzero.

- `CLK` input 1: clock, rising edge.
- `INIT_n` input 1: asynchronous, active-low reset.
- `START` input 1: frame request; sampled only in IDLE.
- `STOP` input 1: abort the running frame.
- `HOLD` input 1: pause; freezes all counters, LFSR and outputs except `EN`.
- `GRAD_MAG` input 8*N: packed magnitudes; channel k is `[k*N +: N]`. Latched on `START` acceptance.
- `GRAD_SIGN` input 8: per-channel sign. Latched on `START` acceptance.
- `IN_SS` output 8: stochastic bits, one per channel.
- `SIGN` output 8: latched signs.
- `regIndex` output 3: active channel.
- `EN` output 1: accumulator update enable.
- `BUSY` output 1: high in RUN.
- `DONE` output 1: one-cycle pulse at frame end.

## Operation
- Reset values: `IN_SS`=0, `SIGN`=0, `regIndex`=0, `EN`=0, `BUSY`=0, `DONE`=0, state IDLE, LFSR=`LFSR_SEED`, sweep counter=0, magnitude/sign shadows=0.
- States and transitions:
  - IDLE -> RUN on `START`=1.
  - RUN -> DONE after the last cycle of sweep `FRAME_LEN-1`.
  - RUN -> IDLE on `STOP`.
  - DONE -> IDLE unconditionally.
- `START` acceptance (IDLE, `START`=1) does all of the following:
  - latches `GRAD_MAG` and `GRAD_SIGN` into the shadows;
  - `SIGN` <= `GRAD_SIGN`;
  - LFSR <= `LFSR_SEED`;
  - `regIndex` <= 0;
  - `IN_SS[0]` <= (`LFSR_SEED` <= mag0);
  - sweep counter <= 0.
- `START` while not in IDLE is ignored. Shadows hold until the next acceptance.
- LFSR: N-bit Fibonacci, x^8+x^6+x^5+x^4+1 for N=8. Shifts left; the new LSB is the XOR of bits 7,5,4,3. Sequence values are 1..255.
- Each non-held RUN cycle:
  - LFSR advances to L';
  - `regIndex` <= (`regIndex`+1) mod 8;
  - `IN_SS[next]` <= (L' <= mag[next]);
  - all other `IN_SS` bits hold.
- Comparison is unsigned. mag=0 always gives 0. mag=2^N-1 always gives 1. Bit density is mag/(2^N-1).
- Sweep counter increments when `regIndex` wraps 7->0. It is 16 bits wide; the frame ends when the counter equals `FRAME_LEN-1` and `regIndex`=7.
- `EN` = RUN & ~`HOLD` (combinational from state register and `HOLD`). The downstream accumulator only sees updates where `EN`=1.
- `STOP` in RUN: next state IDLE, no `DONE` pulse. `IN_SS` is cleared to 0. `SIGN` and `regIndex` hold.
- `STOP` and `HOLD` together: `STOP` wins.
- Reaching DONE: `DONE`=1 for exactly one cycle, `EN`=0, `IN_SS` cleared to 0.
- `INIT_n` low at any time: immediately forces all reset values. A frame in progress is discarded without `DONE`.

## Timing
- Latency `START` sample -> first valid (`regIndex`=0, `IN_SS[0]`, `EN`=1): 1 cycle.
- Frame length in RUN: exactly 8*`FRAME_LEN` non-held cycles. `HOLD` cycles extend the frame one-for-one.
- `DONE` asserts the cycle after the last RUN cycle (`regIndex`=7 of the final sweep). The earliest next `START` acceptance is 2 cycles after `DONE`.
- `BUSY` is high exactly while in RUN, including held cycles.
- All outputs are registered except `EN`. `EN` depends combinationally on `HOLD`; `HOLD` must meet setup to `CLK` in the downstream block.
- Reset deassertion is synchronised externally. The first edge after deassertion may accept `START`.

## Test plan
- Reset and idle: assert `INIT_n`=0 mid-cycle -> all outputs 0 immediately; release and hold `START`=0 for 20 cycles -> outputs stay 0 and `EN`=0.
- Single frame, `FRAME_LEN`=4, all mags 8'hFF, `GRAD_SIGN`=8'h5A:
  - 32 cycles of `EN`=1 with `regIndex` stepping 0..7 four times;
  - `IN_SS[regIndex]`=1 every cycle and `SIGN`=8'h5A;
  - `DONE` pulses once, at cycle 33.
- Density check, `FRAME_LEN`=255: mag ch3=8'h00, ch5=8'h80, ch7=8'hFF -> count of `IN_SS[k]`=1 with `regIndex`=k is 0 for ch3, 128±8 for ch5, 255 for ch7. Compare the ch5 count against a bit-exact LFSR model.
- `HOLD` for 5 cycles at `regIndex`=3 -> `EN`=0; `regIndex`, `IN_SS` and LFSR frozen; frame lasts 5 cycles longer; stream after release matches the unheld model.
- `STOP` at sweep 2, `regIndex`=4 -> next cycle IDLE with `BUSY`=0, `EN`=0, `IN_SS`=0, no `DONE`; a new `START` reloads the seed and restarts at `regIndex`=0.
- `START` pulses during RUN with different `GRAD_MAG` -> ignored; the stream continues from the originally latched mags. `INIT_n` low at sweep 1 -> no `DONE`, all outputs 0.
